// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - PC register with next-PC select and return-address stack check
module pc_next_unit #(
  parameter int XLEN      = 32,
  parameter int IDX_W     = 26,
  parameter int IMM_W     = 16,
  parameter int RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_stall,
  input  logic [1:0]                       i_sel,
  input  logic                             i_taken,
  input  logic [IMM_W-1:0]                 i_imm,
  input  logic [IDX_W-1:0]                 i_idx,
  input  logic [XLEN-1:0]                  i_rs_val,
  input  logic                             i_link,
  input  logic                             i_ret,
  output logic [XLEN-1:0]                  o_pc,
  output logic [XLEN-1:0]                  o_pc_plus4,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   o_ras_count,
  output logic                             o_ras_miss
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic             r_miss;

  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_imm_ext;
  logic [XLEN-1:0]  w_branch;
  logic [XLEN-1:0]  w_jump;
  logic [XLEN-1:0]  w_next_pc;
  logic             w_do_pop;
  logic             w_do_push;
  logic             w_pop_valid;
  logic             w_miss;
  logic [PTR_W-1:0] w_pop_top;
  logic [PTR_W-1:0] w_push_ptr;
  logic [PTR_W-1:0] w_new_top;
  logic [CNT_W-1:0] w_pop_count;
  logic [CNT_W-1:0] w_new_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? LAST : p - 1'b1;
  endfunction

  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_imm_ext  = {{(XLEN-IMM_W){i_imm[IMM_W-1]}}, i_imm};
  assign w_branch   = w_pc_plus4 + (w_imm_ext << 2);

  generate
    if (XLEN > IDX_W + 2) begin : g_upper
      assign w_jump = {w_pc_plus4[XLEN-1:IDX_W+2], i_idx, 2'b00};
    end else begin : g_no_upper
      assign w_jump = {i_idx, 2'b00};
    end
  endgenerate

  always_comb begin
    w_next_pc = w_pc_plus4;
    unique case (i_sel)
      2'b00:   w_next_pc = w_pc_plus4;
      2'b01:   w_next_pc = i_taken ? w_branch : w_pc_plus4;
      2'b10:   w_next_pc = w_jump;
      default: w_next_pc = i_rs_val;
    endcase
  end

  // Pop is resolved before push so a return-and-call reuses the freed slot.
  assign w_do_pop    = i_ret && (i_sel == 2'b11);
  assign w_do_push   = i_link && i_sel[1];
  assign w_pop_valid = w_do_pop && (r_count != '0);
  assign w_miss      = w_do_pop && ((r_count == '0) || (r_ras[r_top] != i_rs_val));
  assign w_pop_top   = w_pop_valid ? ptr_dec(r_top) : r_top;
  assign w_pop_count = w_pop_valid ? r_count - 1'b1 : r_count;
  assign w_push_ptr  = ptr_inc(w_pop_top);
  assign w_new_top   = w_do_push ? w_push_ptr : w_pop_top;
  assign w_new_count = !w_do_push ? w_pop_count :
                       (w_pop_count == FULL) ? FULL : w_pop_count + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc    <= RESET_VECTOR;
      r_top   <= '0;
      r_count <= '0;
      r_miss  <= 1'b0;
    end else if (i_stall) begin
      r_miss  <= 1'b0;
    end else begin
      r_pc    <= w_next_pc;
      r_top   <= w_new_top;
      r_count <= w_new_count;
      r_miss  <= w_miss;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_stall && w_do_push) begin
      r_ras[w_push_ptr] <= w_pc_plus4;
    end
  end

  assign o_pc        = r_pc;
  assign o_pc_plus4  = w_pc_plus4;
  assign o_ras_count = r_count;
  assign o_ras_miss  = r_miss;
endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - directed and random checks of pc_next_unit against a queue-based model
module tb_pc_next_unit;
  logic        clk = 1'b0;
  logic        rst, stall, taken, link, ret;
  logic [1:0]  sel;
  logic [15:0] imm;
  logic [25:0] idx;
  logic [31:0] rs_val;
  logic [31:0] pc, pc_plus4;
  logic [2:0]  ras_count;
  logic        ras_miss;
  logic [27:0] pc28, pc_plus4_28;
  logic [2:0]  ras_count28;
  logic        ras_miss28;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_miss;
  logic [31:0] vals[5];

  always #5 clk = ~clk;

  pc_next_unit #(.XLEN(32), .IDX_W(26), .IMM_W(16), .RAS_DEPTH(4), .RESET_VECTOR(32'h0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_sel(sel), .i_taken(taken),
    .i_imm(imm), .i_idx(idx), .i_rs_val(rs_val), .i_link(link), .i_ret(ret),
    .o_pc(pc), .o_pc_plus4(pc_plus4), .o_ras_count(ras_count), .o_ras_miss(ras_miss)
  );

  pc_next_unit #(.XLEN(28), .IDX_W(26), .IMM_W(16), .RAS_DEPTH(4), .RESET_VECTOR(28'h0)) u_dut28 (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_sel(sel), .i_taken(taken),
    .i_imm(imm), .i_idx(idx), .i_rs_val(rs_val[27:0]), .i_link(link), .i_ret(ret),
    .o_pc(pc28), .o_pc_plus4(pc_plus4_28), .o_ras_count(ras_count28), .o_ras_miss(ras_miss28)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: architectural next-PC rules plus a bounded LIFO of link addresses.
  task automatic model_update();
    logic [31:0] p4, e;
    int off;
    if (rst) begin
      m_pc = 32'h0; m_q.delete(); m_miss = 1'b0;
    end else if (stall) begin
      m_miss = 1'b0;
    end else begin
      p4 = m_pc + 32'd4;
      m_miss = 1'b0;
      if (sel == 2'b11 && ret) begin
        if (m_q.size() == 0) m_miss = 1'b1;
        else begin
          e = m_q.pop_back();
          m_miss = (e != rs_val);
        end
      end
      if (sel[1] && link) begin
        m_q.push_back(p4);
        if (m_q.size() > 4) void'(m_q.pop_front());
      end
      case (sel)
        2'b00: m_pc = p4;
        2'b01: begin
          off = $signed(imm);
          m_pc = taken ? p4 + 32'(off * 4) : p4;
        end
        2'b10: m_pc = (p4 & 32'hF000_0000) | (32'(idx) * 32'd4);
        default: m_pc = rs_val;
      endcase
    end
  endtask

  task automatic cyc(input string tag, input logic [1:0] s, input logic tk, input logic [15:0] im,
                     input logic [25:0] ix, input logic [31:0] rv, input logic lk, input logic rt,
                     input logic st, input logic rs_in);
    sel = s; taken = tk; imm = im; idx = ix; rs_val = rv; link = lk; ret = rt; stall = st; rst = rs_in;
    model_update();
    @(posedge clk);
    #1;
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_pc4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, "_cnt"}, 32'(ras_count), 32'(m_q.size()));
    chk({tag, "_miss"}, 32'(ras_miss), 32'(m_miss));
  endtask

  task automatic seq_c(input string tag);            cyc(tag, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic jr_c(input string tag, input logic [31:0] t); cyc(tag, 2'b11, 0, 0, 0, t, 0, 0, 0, 0); endtask
  task automatic rst_c(input string tag);            cyc(tag, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1); endtask

  initial begin
    m_pc = 32'h0; m_miss = 1'b0;
    // reset and sequential flow
    rst_c("rst0");
    rst_c("rst1");
    chk("rst_pc", pc, 32'h0);
    chk("rst_cnt", 32'(ras_count), 32'h0);
    seq_c("seq1"); chk("seq1_k", pc, 32'h4);
    seq_c("seq2"); chk("seq2_k", pc, 32'h8);
    seq_c("seq3"); chk("seq3_k", pc, 32'hC);
    jr_c("to_top", 32'hFFFF_FFFC);
    seq_c("wrap"); chk("wrap_k", pc, 32'h0);
    jr_c("to_top2", 32'hFFFF_FFFC);
    rst_c("rst_top"); chk("rst_top_k", pc, 32'h0);
    seq_c("post_rst"); chk("post_rst_k", pc, 32'h4);

    // branches
    jr_c("b0", 32'h100);
    cyc("br_t", 2'b01, 1, 16'hFFFE, 0, 0, 0, 0, 0, 0); chk("br_t_k", pc, 32'h0FC);
    jr_c("b1", 32'h100);
    cyc("br_nt", 2'b01, 0, 16'hFFFE, 0, 0, 0, 0, 0, 0); chk("br_nt_k", pc, 32'h104);
    jr_c("b2", 32'h0);
    cyc("br_max", 2'b01, 1, 16'h7FFF, 0, 0, 0, 0, 0, 0); chk("br_max_k", pc, 32'h20000);

    // jump with upper bits, and narrow-XLEN build with none
    jr_c("j0", 32'h9000_0010);
    cyc("jump", 2'b10, 0, 0, 26'h123, 0, 0, 0, 0, 0);
    chk("jump_k", pc, 32'h9000_048C);
    chk("jump_x28", {4'h0, pc28}, 32'h0000_048C);

    // balanced call/return
    rst_c("rb0");
    jr_c("rb1", 32'h40);
    cyc("jal1", 2'b10, 0, 0, 26'h80, 0, 1, 0, 0, 0);  chk("jal1_k", pc, 32'h200);
    cyc("jal2", 2'b10, 0, 0, 26'h400, 0, 1, 0, 0, 0); chk("jal2_cnt_k", 32'(ras_count), 32'd2);
    cyc("ret1", 2'b11, 0, 0, 0, 32'h204, 0, 1, 0, 0); chk("ret1_k", pc, 32'h204);
    cyc("ret2", 2'b11, 0, 0, 0, 32'h44, 0, 1, 0, 0);
    chk("ret2_k", pc, 32'h44);
    chk("ret2_miss_k", 32'(ras_miss), 32'd0);

    // depth boundaries
    rst_c("bd0");
    for (int i = 0; i < 5; i++) begin
      vals[i] = m_pc + 32'd4;
      cyc("push", 2'b11, 0, 0, 0, 32'h1000 * (i + 1), 1, 0, 0, 0);
    end
    chk("full_cnt_k", 32'(ras_count), 32'd4);
    for (int i = 4; i >= 1; i--) cyc("pop", 2'b11, 0, 0, 0, vals[i], 0, 1, 0, 0);
    chk("drained_k", 32'(ras_count), 32'd0);
    cyc("pop_empty", 2'b11, 0, 0, 0, vals[0], 0, 1, 0, 0);
    chk("empty_miss_k", 32'(ras_miss), 32'd1);
    seq_c("miss_pulse"); chk("miss_pulse_k", 32'(ras_miss), 32'd0);
    cyc("push1", 2'b10, 0, 0, 26'h10, 0, 1, 0, 0, 0);
    cyc("pop_bad", 2'b11, 0, 0, 0, 32'hDEAD_BEE0, 0, 1, 0, 0);
    chk("bad_miss_k", 32'(ras_miss), 32'd1);
    cyc("retlink", 2'b11, 0, 0, 0, 32'h300, 1, 1, 0, 0);
    chk("retlink_miss_k", 32'(ras_miss), 32'd1);
    chk("retlink_cnt_k", 32'(ras_count), 32'd1);

    // stall, then reset overriding stall
    cyc("st_push", 2'b10, 0, 0, 26'h20, 0, 1, 0, 0, 0);
    cyc("st_bad", 2'b11, 0, 0, 0, 32'h4, 0, 1, 0, 0);
    chk("st_bad_k", 32'(ras_miss), 32'd1);
    for (int i = 0; i < 3; i++) cyc("stall", 2'b10, 0, 0, 26'h55, 0, 1, 0, 1, 0);
    chk("stall_pc_k", pc, 32'h4);
    chk("stall_cnt_k", 32'(ras_count), 32'd1);
    cyc("rst_stall", 2'b11, 0, 0, 0, 32'h8, 1, 1, 1, 1);
    chk("rst_stall_pc_k", pc, 32'h0);
    chk("rst_stall_cnt_k", 32'(ras_count), 32'd0);
    chk("rst_stall_miss_k", 32'(ras_miss), 32'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0]  s;
      logic        rt, lk;
      logic [31:0] rv;
      s  = 2'($urandom_range(0, 3));
      rt = ($urandom_range(0, 1) == 1);
      lk = ($urandom_range(0, 1) == 1);
      rv = $urandom & 32'hFFFF_FFFC;
      if (rt && m_q.size() > 0 && $urandom_range(0, 3) != 0) rv = m_q[$];
      cyc("rnd", s, 1'($urandom_range(0, 1)), 16'($urandom), 26'($urandom), rv, lk, rt,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
